div: RTL



---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 28 ++
 rtl/div.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: bus widths, state encodings and handshake levels.
// Used by div and div_step; see div.sv for the DIV_ZERO_FAST_EN build option.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement negate when requested; used both for operand magnitudes and result fix-up.
    function automatic logic [RegBus-1:0] neg_if(input logic [RegBus-1:0] v, input logic neg);
        return neg ? (~v + {{(RegBus-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the partial
// remainder, subtracts the divisor and keeps the difference only when it did not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [RegBus-1:0] r,
    input  logic [RegBus-1:0] q,
    input  logic [RegBus-1:0] d,
    output logic [RegBus-1:0] r_next,
    output logic [RegBus-1:0] q_next
);

    logic [RegBus:0] partial;
    logic [RegBus:0] diff;

    always_comb begin
        partial = {r, q[RegBus-1]};
        diff    = partial - {1'b0, d};
        if (!diff[RegBus]) begin
            r_next = diff[RegBus-1:0];
            q_next = {q[RegBus-2:0], 1'b1};
        end else begin
            r_next = partial[RegBus-1:0];
            q_next = {q[RegBus-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div.sv
// Iterative 32-bit DIV/DIVU unit, one quotient bit per clock, with flush abort.
// Build option DIV_ZERO_FAST_EN: a zero divisor short-circuits to a zero result in two edges.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e state, state_next;

    logic [4:0]              cnt, cnt_next;
    logic [RegBus-1:0]       r, r_next;
    logic [RegBus-1:0]       q, q_next;
    logic [RegBus-1:0]       d, d_next;
    logic                    neg_q, neg_q_next;
    logic                    neg_r, neg_r_next;
    logic [DoubleRegBus-1:0] result_next;
    logic                    ready_next;

    logic [RegBus-1:0]       step_r;
    logic [RegBus-1:0]       step_q;
    logic                    sign1;
    logic                    sign2;

    div_step u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (step_r),
        .q_next (step_q)
    );

    assign sign1 = signed_div_i & opdata1_i[RegBus-1];
    assign sign2 = signed_div_i & opdata2_i[RegBus-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            r        <= ZeroWord;
            q        <= ZeroWord;
            d        <= ZeroWord;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= {ZeroWord, ZeroWord};
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            r        <= r_next;
            q        <= q_next;
            d        <= d_next;
            neg_q    <= neg_q_next;
            neg_r    <= neg_r_next;
            result_o <= result_next;
            ready_o  <= ready_next;
        end
    end

    // The dividend magnitude lives in q and is shifted out as quotient bits are shifted in.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        r_next      = r;
        q_next      = q;
        d_next      = d;
        neg_q_next  = neg_q;
        neg_r_next  = neg_r;
        result_next = result_o;
        ready_next  = ready_o;

        case (state)
            DivFree: begin
                result_next = {ZeroWord, ZeroWord};
                ready_next  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    cnt_next   = '0;
                    r_next     = ZeroWord;
                    q_next     = neg_if(opdata1_i, sign1);
                    d_next     = neg_if(opdata2_i, sign2);
                    neg_q_next = sign1 ^ sign2;
                    neg_r_next = sign1;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == ZeroWord) begin
                        state_next = DivByZero;
                    end else begin
                        state_next = DivOn;
                    end
`else
                    state_next = DivOn;
`endif
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else begin
                    state_next  = DivEnd;
                    result_next = {ZeroWord, ZeroWord};
                    ready_next  = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else begin
                    r_next   = step_r;
                    q_next   = step_q;
                    cnt_next = cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state_next  = DivEnd;
                        result_next = {neg_if(step_r, neg_r), neg_if(step_q, neg_q)};
                        ready_next  = DivResultReady;
                    end
                end
            end

            DivEnd: begin
                if (start_i == DivStop) begin
                    state_next  = DivFree;
                    result_next = {ZeroWord, ZeroWord};
                    ready_next  = DivResultNotReady;
                end
            end

            default: begin
                state_next = DivFree;
            end
        endcase
    end

endmodule
